fp_normalize_pack: RTL and testbench

- Downstream stage of the single-precision adder datapath.
- Consumes the raw sum as sign, larger-operand exponent and unnormalized mantissa, with possible carry-out or leading zeros.
- Normalizes iteratively, one shift per cycle, handles zero, overflow and underflow, and emits a packed IEEE-754 single-precision word.
- Rounding mode is truncation.

---
 rtl/fp_normalize_pack.sv | 150 +++++++++++++++
 tb/tb_fp_normalize_pack.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_normalize_pack.sv
// Final stage of the single-precision adder: normalizes the raw sum one bit per
// cycle, resolves zero/infinity/underflow, and packs the IEEE-754 word (truncating).
module fp_normalize_pack #(
  parameter int MANT_W = 25,
  parameter int EXP_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out,
  output logic [31:0]       debug
);

  localparam int FRAC_W = MANT_W - 2;
  localparam int CNT_W  = 5;
  localparam logic [EXP_W-1:0] EXP_MAX = '1;

  typedef enum logic [1:0] {IDLE, CHECK, SHIFT, DONE} state_t;

  state_t              state_reg, state_next;
  logic                sign_reg, sign_next;
  logic [EXP_W-1:0]    exp_reg, exp_next;
  logic [MANT_W-1:0]   mant_reg, mant_next;
  logic [CNT_W-1:0]    count_reg, count_next;
  logic [31:0]         out_reg, out_next;
  logic [31:0]         debug_reg, debug_next;

  logic [EXP_W-1:0]    exp_inc;
  logic [MANT_W-1:0]   mant_shr;
  logic [31:0]         zero_word;
  logic [31:0]         inf_word;
  logic [31:0]         count_ext;

  assign exp_inc   = exp_reg + EXP_W'(1);
  assign mant_shr  = mant_reg >> 1;
  assign zero_word = {sign_reg, {(31){1'b0}}};
  assign inf_word  = {sign_reg, EXP_MAX, {FRAC_W{1'b0}}};
  assign count_ext = {{(32-CNT_W){1'b0}}, count_reg};

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign out       = out_reg;
  assign debug     = debug_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sign_reg  <= 1'b0;
      exp_reg   <= '0;
      mant_reg  <= '0;
      count_reg <= '0;
      out_reg   <= '0;
      debug_reg <= '0;
    end else begin
      sign_reg  <= sign_next;
      exp_reg   <= exp_next;
      mant_reg  <= mant_next;
      count_reg <= count_next;
      out_reg   <= out_next;
      debug_reg <= debug_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    sign_next  = sign_reg;
    exp_next   = exp_reg;
    mant_next  = mant_reg;
    count_next = count_reg;
    out_next   = out_reg;
    debug_next = debug_reg;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          sign_next  = in_sign;
          exp_next   = in_exp;
          mant_next  = in_mant;
          count_next = '0;
          state_next = CHECK;
        end
      end

      CHECK: begin
        state_next = DONE;
        debug_next = count_ext;
        if (exp_reg == EXP_MAX) begin
          out_next = inf_word;
        end else if (mant_reg == '0 || exp_reg == '0) begin
          out_next = zero_word;
        end else if (mant_reg[MANT_W-1]) begin
          // Carry-out: renormalize right by one; overflow lands on infinity.
          mant_next = mant_shr;
          exp_next  = exp_inc;
          if (exp_inc == EXP_MAX) begin
            out_next = inf_word;
          end else begin
            out_next = {sign_reg, exp_inc, mant_shr[FRAC_W-1:0]};
          end
        end else if (mant_reg[MANT_W-2]) begin
          out_next = {sign_reg, exp_reg, mant_reg[FRAC_W-1:0]};
        end else begin
          state_next = SHIFT;
          debug_next = debug_reg;
        end
      end

      SHIFT: begin
        if (mant_reg[MANT_W-2]) begin
          out_next   = {sign_reg, exp_reg, mant_reg[FRAC_W-1:0]};
          debug_next = count_ext;
          state_next = DONE;
        end else if (exp_reg > EXP_W'(1)) begin
          mant_next  = mant_reg << 1;
          exp_next   = exp_reg - EXP_W'(1);
          count_next = count_reg + CNT_W'(1);
        end else begin
          // Exponent exhausted before the hidden one surfaced: flush to zero.
          out_next   = zero_word;
          debug_next = count_ext;
          state_next = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fp_normalize_pack.sv
// Directed checks of fp_normalize_pack against an arithmetic reference model:
// packed result, shift count, latency, handshake and backpressure behaviour.
module tb_fp_normalize_pack;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [24:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic [31:0] debug;

  int          n_cmp;
  int          n_bad;
  logic [31:0] exp_out;
  logic [31:0] exp_dbg;
  logic [31:0] idle_out;
  logic [31:0] idle_dbg;
  bit          checking;

  fp_normalize_pack dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .debug     (debug)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Reference: locate the leading one, then decide how many left shifts the
  // exponent can afford; latency counts edges from the accept edge inclusive.
  function automatic void model(input logic s, input logic [7:0] e, input logic [24:0] m,
                                output logic [31:0] o, output int d, output int lat);
    int          p;
    int          k;
    int          ei;
    logic [24:0] mm;
    logic [7:0]  eb;
    ei  = int'(e);
    d   = 0;
    lat = 2;
    p   = 0;
    if (ei == 255) begin
      o = {s, 8'hFF, 23'b0};
    end else if (m == 25'd0 || ei == 0) begin
      o = {s, 31'b0};
    end else if (m[24]) begin
      mm = m >> 1;
      eb = e + 8'd1;
      if (ei + 1 == 255) o = {s, 8'hFF, 23'b0};
      else               o = {s, eb, mm[22:0]};
    end else begin
      for (int i = 0; i < 24; i++) if (m[i]) p = i;
      k = 23 - p;
      if (k == 0) begin
        o = {s, e, m[22:0]};
      end else if (k <= ei - 1) begin
        mm  = m << k;
        eb  = 8'(ei - k);
        o   = {s, eb, mm[22:0]};
        d   = k;
        lat = 3 + k;
      end else begin
        o   = {s, 31'b0};
        d   = ei - 1;
        lat = 3 + ei - 1;
      end
    end
  endfunction

  // Output checker: in DONE the word must match the model; in IDLE it must
  // still show the last completed result.
  always @(negedge clk) begin
    if (!reset && checking) begin
      if (out_valid) begin
        check("out", out, exp_out);
        check("debug", debug, exp_dbg);
        check("in_ready_in_done", {31'b0, in_ready}, 32'd0);
      end else if (in_ready) begin
        check("idle_out", out, idle_out);
        check("idle_debug", debug, idle_dbg);
      end
    end
  end

  task automatic run_op(input logic s, input logic [7:0] e, input logic [24:0] m, input int hold,
                        input bit use_lit, input logic [31:0] lit_out, input int lit_dbg, input int lit_lat);
    logic [31:0] mo;
    int          md;
    int          ml;
    int          n;
    bit          seen;
    model(s, e, m, mo, md, ml);
    if (use_lit) begin
      check("model_out", mo, lit_out);
      check("model_debug", md, lit_dbg);
      check("model_latency", ml, lit_lat);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    exp_out  = mo;
    exp_dbg  = 32'(md);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sign  = 1'($urandom);
    in_exp   = 8'($urandom);
    in_mant  = 25'($urandom);
    n    = 1;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
      end else begin
        check("in_ready_busy", {31'b0, in_ready}, 32'd0);
        n++;
      end
    end
    if (!seen) begin
      check("out_valid_timeout", 32'd0, 32'd1);
      return;
    end
    check("latency", n, ml);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_mant  = 25'($urandom);
      @(negedge clk);
      check("bp_out_valid", {31'b0, out_valid}, 32'd1);
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
    end
    // Offer an input in the handoff cycle; it must not be taken.
    in_valid  = (hold > 0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    idle_out  = mo;
    idle_dbg  = 32'(md);
    @(negedge clk);
    check("handoff_out_valid", {31'b0, out_valid}, 32'd0);
    check("handoff_in_ready", {31'b0, in_ready}, 32'd1);
    $display("op s=%0d e=%h m=%h -> out=%h debug=%0d latency=%0d", s, e, m, out, debug, n);
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    checking  = 1'b0;
    idle_out  = 32'd0;
    idle_dbg  = 32'd0;
    exp_out   = 32'd0;
    exp_dbg   = 32'd0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = 8'd0;
    in_mant   = 25'd0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", out, 32'd0);
    check("rst_debug", debug, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    reset    = 1'b0;
    checking = 1'b1;

    run_op(1'b0, 8'h84, 25'h0A00000, 0, 1'b1, 32'h42200000, 0, 2);
    run_op(1'b0, 8'h84, 25'h1400000, 0, 1'b1, 32'h42A00000, 0, 2);
    run_op(1'b0, 8'hFE, 25'h1000000, 0, 1'b1, 32'h7F800000, 0, 2);
    run_op(1'b1, 8'h82, 25'h0200000, 0, 1'b1, 32'hC0000000, 2, 5);
    run_op(1'b1, 8'h10, 25'h0000000, 0, 1'b1, 32'h80000000, 0, 2);
    run_op(1'b0, 8'h02, 25'h0000400, 0, 1'b1, 32'h00000000, 1, 4);
    run_op(1'b1, 8'hFF, 25'h0800000, 0, 1'b1, 32'hFF800000, 0, 2);
    run_op(1'b0, 8'h00, 25'h0800000, 0, 1'b1, 32'h00000000, 0, 2);
    run_op(1'b0, 8'h80, 25'h0000001, 0, 1'b1, 32'h34800000, 23, 26);
    run_op(1'b0, 8'h03, 25'h0200000, 0, 1'b1, 32'h00800000, 2, 5);
    run_op(1'b1, 8'h01, 25'h0400000, 0, 1'b1, 32'h80000000, 0, 3);
    run_op(1'b1, 8'h7F, 25'h0C00000, 10, 1'b1, 32'hBFC00000, 0, 2);

    // Abort an operation partway through its shifts.
    @(negedge clk);
    in_valid = 1'b1;
    in_sign  = 1'b1;
    in_exp   = 8'h82;
    in_mant  = 25'h0200000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    idle_out = 32'd0;
    idle_dbg = 32'd0;
    reset    = 1'b1;
    #1;
    check("abort_out", out, 32'd0);
    check("abort_debug", debug, 32'd0);
    check("abort_out_valid", {31'b0, out_valid}, 32'd0);
    check("abort_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    $display("op reset mid-shift -> out=%h debug=%0d", out, debug);
    run_op(1'b0, 8'h84, 25'h0A00000, 0, 1'b1, 32'h42200000, 0, 2);

    for (int t = 0; t < 8; t++) begin
      run_op(1'($urandom), 8'($urandom_range(0, 255)), 25'($urandom) >> $urandom_range(0, 24),
             int'($urandom_range(0, 3)), 1'b0, 32'd0, 0, 0);
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
